// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS time-setting controller: mode encodings,
// BCD limits, blink-mask bit positions and the BCD field increment rule.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_e;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam logic [3:0] HR_MAX_TENS = 4'd2;
  localparam logic [3:0] HR_MAX_ONES = 4'd3;
  localparam logic [3:0] MS_MAX_TENS = 4'd5;
  localparam logic [3:0] MS_MAX_ONES = 4'd9;

  localparam int BLINK_H1 = 5;
  localparam int BLINK_H0 = 4;
  localparam int BLINK_M1 = 3;
  localparam int BLINK_M0 = 2;
  localparam int BLINK_S1 = 1;
  localparam int BLINK_S0 = 0;

  // Two-digit BCD increment that wraps to 00 after {max_tens,max_ones}.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input logic [3:0] max_tens,
                                         input logic [3:0] max_ones);
    if (tens == max_tens && ones == max_ones) begin
      return 8'h00;
    end else if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bus between the time-setting controller and the counter/display chain.
interface clock_set_ctrl_if;
  // Strobe semantics: load is a single-cycle strobe that the counters must
  // take in preference to run_en; run_en is a level enable (no ready/back-pressure).
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
  logic       run_en;
  logic       load;
  logic [3:0] set_h1, set_h0, set_m1, set_m0, set_s1, set_s0;
  logic       disp_shadow;
  logic [5:0] blink_mask;
  logic [1:0] mode;

  modport master (
    input  cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
    output run_en, load, set_h1, set_h0, set_m1, set_m0, set_s1, set_s0,
    output disp_shadow, blink_mask, mode
  );

  modport slave (
    output cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
    input  run_en, load, set_h1, set_h0, set_m1, set_m0, set_s1, set_s0,
    input  disp_shadow, blink_mask, mode
  );
endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// Push-button debouncer: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced mode/increment buttons drive a RUN/SET
// mode FSM that edits a shadow BCD time and loads it back into the counters.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode_raw_i,
  input  logic btn_inc_raw_i,
  output logic dbg_mode_level_o,
  output logic dbg_inc_level_o,
  clock_set_ctrl_if.master bus
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic mode_press, inc_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode_raw_i),
    .level (dbg_mode_level_o),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc_raw_i),
    .level (dbg_inc_level_o),
    .press (inc_press)
  );

  mode_e         state_q, state_d;
  bcd_time_t     set_q, set_d;
  logic          load_q, load_d;
  logic          ph_q, ph_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [5:0]    blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MODE_RUN;
      set_q   <= '0;
      load_q  <= 1'b0;
      ph_q    <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      load_q  <= load_d;
      ph_q    <= ph_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // A mode press takes precedence; a coincident increment is dropped.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    load_d  = 1'b0;
    if (mode_press) begin
      case (state_q)
        MODE_RUN: begin
          state_d = MODE_SET_HR;
          set_d   = '{h1: bus.cur_h1, h0: bus.cur_h0, m1: bus.cur_m1,
                      m0: bus.cur_m0, s1: bus.cur_s1, s0: bus.cur_s0};
        end
        MODE_SET_HR:  state_d = MODE_SET_MIN;
        MODE_SET_MIN: state_d = MODE_SET_SEC;
        default: begin
          state_d = MODE_RUN;
          load_d  = 1'b1;
        end
      endcase
    end else if (inc_press) begin
      case (state_q)
        MODE_SET_HR:
          {set_d.h1, set_d.h0} = bcd_inc(set_q.h1, set_q.h0, HR_MAX_TENS, HR_MAX_ONES);
        MODE_SET_MIN:
          {set_d.m1, set_d.m0} = bcd_inc(set_q.m1, set_q.m0, MS_MAX_TENS, MS_MAX_ONES);
        MODE_SET_SEC:
          {set_d.s1, set_d.s0} = bcd_inc(set_q.s1, set_q.s0, MS_MAX_TENS, MS_MAX_ONES);
        default: ;
      endcase
    end
  end

  // Blink phase restarts visible on every mode change.
  always_comb begin
    ph_d   = ph_q;
    bcnt_d = bcnt_q + 1'b1;
    if (state_d != state_q) begin
      ph_d   = 1'b0;
      bcnt_d = '0;
    end else if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
      ph_d   = ~ph_q;
      bcnt_d = '0;
    end
  end

  always_comb begin
    blink = '0;
    case (state_q)
      MODE_SET_HR: begin
        blink[BLINK_H1] = ph_q;
        blink[BLINK_H0] = ph_q;
      end
      MODE_SET_MIN: begin
        blink[BLINK_M1] = ph_q;
        blink[BLINK_M0] = ph_q;
      end
      MODE_SET_SEC: begin
        blink[BLINK_S1] = ph_q;
        blink[BLINK_S0] = ph_q;
      end
      default: ;
    endcase
  end

  assign bus.mode        = state_q;
  assign bus.run_en      = (state_q == MODE_RUN);
  assign bus.disp_shadow = (state_q != MODE_RUN);
  assign bus.load        = load_q;
  assign bus.blink_mask  = blink;
  assign bus.set_h1      = set_q.h1;
  assign bus.set_h0      = set_q.h0;
  assign bus.set_m1      = set_q.m1;
  assign bus.set_m0      = set_q.m0;
  assign bus.set_s1      = set_q.s1;
  assign bus.set_s0      = set_q.s0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl against a plain-arithmetic time model.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  localparam int DEB  = 16;
  localparam int BLK  = 8;
  localparam int HOLD = DEB + 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_mode_raw, btn_inc_raw;
  logic dbg_ml, dbg_il;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_mode_raw_i   (btn_mode_raw),
    .btn_inc_raw_i    (btn_inc_raw),
    .dbg_mode_level_o (dbg_ml),
    .dbg_inc_level_o  (dbg_il),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode as 0..3, shadow and live time as plain integers.
  int m_mode, m_h, m_m, m_s;
  int cur_h, cur_m, cur_s;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [2:0]  obs_ctl_q[$];

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] obs_set();
    return {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0, bus.set_s1, bus.set_s0};
  endfunction

  task automatic set_cur(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0, bus.cur_s1, bus.cur_s0} = to_bcd(h, m, s);
  endtask

  task automatic model_press(input bit pm, input bit pi);
    if (pm) begin
      case (m_mode)
        0: begin m_h = cur_h; m_m = cur_m; m_s = cur_s; m_mode = 1; end
        1: m_mode = 2;
        2: m_mode = 3;
        default: begin m_mode = 0; exp_q.push_back(to_bcd(m_h, m_m, m_s)); end
      endcase
    end else if (pi) begin
      case (m_mode)
        1: m_h = (m_h + 1) % 24;
        2: m_m = (m_m + 1) % 60;
        3: m_s = (m_s + 1) % 60;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_mode_raw = 1'b0;
    btn_inc_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
    exp_q.delete();
    obs_q.delete();
    obs_ctl_q.delete();
  endtask

  // Driver: one clean press/release, recording every cycle in which load is high.
  task automatic press(input bit pm, input bit pi);
    btn_mode_raw = pm;
    btn_inc_raw = pi;
    for (int c = 0; c < 2 * HOLD; c++) begin
      if (c == HOLD) begin
        btn_mode_raw = 1'b0;
        btn_inc_raw = 1'b0;
      end
      @(negedge clk);
      if (bus.load === 1'b1) begin
        obs_q.push_back(obs_set());
        obs_ctl_q.push_back({bus.mode, bus.run_en});
      end
    end
    model_press(pm, pi);
  endtask

  task automatic test_reset();
    logic [34:0] got;
    set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    reset = 1'b1;
    btn_mode_raw = 1'b0;
    btn_inc_raw = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.mode, bus.run_en, bus.load, bus.disp_shadow, bus.blink_mask, obs_set()};
    checks++;
    if (got !== {2'b00, 1'b1, 1'b0, 1'b0, 6'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", got, {2'b00, 1'b1, 1'b0, 1'b0, 6'b0, 24'h0});
    end
    reset = 1'b0;
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = {bus.mode, bus.run_en, bus.load, bus.disp_shadow, bus.blink_mask, obs_set()};
      checks++;
      if (got !== {2'b00, 1'b1, 1'b0, 1'b0, 6'b0, 24'h0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", i, got,
                 {2'b00, 1'b1, 1'b0, 1'b0, 6'b0, 24'h0});
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_mode;
    do_reset();
    set_cur(7, 8, 9);
    for (int g = 0; g < 3; g++) begin
      btn_mode_raw = (g != 1);
      repeat (5) @(negedge clk);
    end
    btn_mode_raw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mode !== 2'b00) begin
        errors++;
        $display("FAIL bounce_reject cyc %0d: got mode %b expected 00", i, bus.mode);
      end
    end
    btn_mode_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_mode = (k >= DEB + 3) ? 2'b01 : 2'b00;
      checks++;
      if (bus.mode !== exp_mode) begin
        errors++;
        $display("FAIL bounce_hold edge %0d: got mode %b expected %b", k, bus.mode, exp_mode);
      end
    end
    btn_mode_raw = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_press(1'b1, 1'b0);
    checks++;
    if ({bus.mode, obs_set()} !== {2'(m_mode), to_bcd(m_h, m_m, m_s)}) begin
      errors++;
      $display("FAIL bounce_release: got %h expected %h", {bus.mode, obs_set()},
               {2'(m_mode), to_bcd(m_h, m_m, m_s)});
    end
  endtask

  task automatic test_capture_blink();
    logic [1:0] prev;
    logic [5:0] exp_mask;
    logic       ph;
    int         w;
    do_reset();
    set_cur(12, 34, 56);
    for (int target = 1; target <= 3; target++) begin
      prev = bus.mode;
      btn_mode_raw = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (bus.mode === prev && w < 60);
      model_press(1'b1, 1'b0);
      checks++;
      if ({bus.mode, bus.run_en, bus.disp_shadow, obs_set()} !== {2'(target), 1'b0, 1'b1, to_bcd(12, 34, 56)}) begin
        errors++;
        $display("FAIL capture mode %0d: got %h expected %h", target,
                 {bus.mode, bus.run_en, bus.disp_shadow, obs_set()},
                 {2'(target), 1'b0, 1'b1, to_bcd(12, 34, 56)});
      end
      for (int n = 0; n < 2 * BLK + 4; n++) begin
        ph = ((n / BLK) % 2) == 1;
        exp_mask = 6'b0;
        if (ph) exp_mask = (target == 1) ? 6'b110000 : (target == 2) ? 6'b001100 : 6'b000011;
        checks++;
        if (bus.blink_mask !== exp_mask) begin
          errors++;
          $display("FAIL blink mode %0d cyc %0d: got %b expected %b", target, n, bus.blink_mask, exp_mask);
        end
        @(negedge clk);
      end
      btn_mode_raw = 1'b0;
      repeat (HOLD) @(negedge clk);
    end
    press(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL capture_load: got no load expected %h", e);
      end else if (obs_q[0] !== e) begin
        errors++;
        $display("FAIL capture_load: got %h expected %h", obs_q.pop_front(), e);
      end else begin
        void'(obs_q.pop_front());
      end
    end
  endtask

  task automatic test_wrap_load();
    bit pm_seq[7] = '{1, 0, 0, 1, 0, 1, 0};
    do_reset();
    set_cur(22, 59, 9);
    for (int i = 0; i < 7; i++) begin
      press(pm_seq[i], !pm_seq[i]);
      checks++;
      if ({bus.mode, obs_set()} !== {2'(m_mode), to_bcd(m_h, m_m, m_s)}) begin
        errors++;
        $display("FAIL wrap step %0d: got %h expected %h", i, {bus.mode, obs_set()},
                 {2'(m_mode), to_bcd(m_h, m_m, m_s)});
      end
    end
    press(1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL wrap_load_count: got %0d loads expected %0d", obs_q.size(), exp_q.size());
    end else begin
      checks++;
      if ({obs_ctl_q[0], obs_q[0]} !== {3'b001, exp_q[0]}) begin
        errors++;
        $display("FAIL wrap_load_value: got %h expected %h", {obs_ctl_q[0], obs_q[0]}, {3'b001, exp_q[0]});
      end
    end
    checks++;
    if ({bus.mode, bus.run_en, bus.load, obs_set()} !== {2'b00, 1'b1, 1'b0, to_bcd(m_h, m_m, m_s)}) begin
      errors++;
      $display("FAIL wrap_after_load: got %h expected %h", {bus.mode, bus.run_en, bus.load, obs_set()},
               {2'b00, 1'b1, 1'b0, to_bcd(m_h, m_m, m_s)});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checks++;
    if ({bus.mode, obs_set()} !== {2'(m_mode), to_bcd(m_h, m_m, m_s)}) begin
      errors++;
      $display("FAIL simultaneous: got %h expected %h", {bus.mode, obs_set()},
               {2'(m_mode), to_bcd(m_h, m_m, m_s)});
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      set_cur(($urandom_range(0, 1) == 1) ? $urandom_range(20, 23) : $urandom_range(0, 23),
              $urandom_range(55, 59), $urandom_range(0, 59));
      n = $urandom_range(0, 2);
      for (int r = 0; r < n; r++) press(1'b0, 1'b1);
      for (int f = 0; f < 4; f++) begin
        press(1'b1, 1'b0);
        n = (f < 3) ? $urandom_range(0, 3) : 0;
        for (int r = 0; r < n; r++) press(1'b0, 1'b1);
        checks++;
        if ({bus.mode, bus.run_en, bus.disp_shadow, obs_set()} !==
            {2'(m_mode), m_mode == 0, m_mode != 0, to_bcd(m_h, m_m, m_s)}) begin
          errors++;
          $display("FAIL random it %0d field %0d: got %h expected %h", it, f,
                   {bus.mode, bus.run_en, bus.disp_shadow, obs_set()},
                   {2'(m_mode), m_mode == 0, m_mode != 0, to_bcd(m_h, m_m, m_s)});
        end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_load_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [23:0] e, o;
      logic [2:0]  c;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      c = obs_ctl_q.pop_front();
      checks++;
      if ({c, o} !== {3'b001, e}) begin
        errors++;
        $display("FAIL random_load: got %h expected %h", {c, o}, {3'b001, e});
      end
    end
  endtask

  task automatic test_reset_mid();
    int loads;
    do_reset();
    set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (bus.mode !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_pre: got mode %b expected 10", bus.mode);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.mode, bus.run_en, bus.load, obs_set()} !== {2'b00, 1'b1, 1'b0, 24'h0}) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h",
               {bus.mode, bus.run_en, bus.load, obs_set()}, {2'b00, 1'b1, 1'b0, 24'h0});
    end
    loads = 0;
    repeat (3) begin
      @(negedge clk);
      loads += int'(bus.load === 1'b1);
    end
    reset = 1'b0;
    m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
    repeat (10) begin
      @(negedge clk);
      loads += int'(bus.load === 1'b1);
    end
    checks++;
    if ({loads, bus.mode, obs_set()} !== {32'd0, 2'b00, 24'h0}) begin
      errors++;
      $display("FAIL reset_mid_after: got loads %0d mode %b set %h expected 0 00 000000",
               loads, bus.mode, obs_set());
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_mode_raw = 1'b0;
    btn_inc_raw = 1'b0;
    set_cur(0, 0, 0);
    test_reset();
    test_bounce();
    test_capture_blink();
    test_wrap_load();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
